// File: rtl/input_pkg.sv
// ---------------------------------------------------------------------------
// input_pkg
//
// Purpose:
//   Shared definitions for the button input front end. These are the button
//   index constants, the button count and the button vector type. It also
//   provides a helper that sizes the debounce counter.
//
// Contents:
//   NUM_BTNS         number of board buttons (6)
//   NUM_REPEAT_BTNS  buttons eligible for auto-repeat (left/right/up/down)
//   BTN_*            bit positions inside a btn_vec_t
//   btn_vec_t        one bit per button
//   cnt_width()      counter width for a given cycle count, never below 1
// ---------------------------------------------------------------------------
package input_pkg;

  localparam int NUM_BTNS        = 6;
  localparam int NUM_REPEAT_BTNS = 4;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_DOWN  = 3;
  localparam int BTN_CHOP  = 4;
  localparam int BTN_CARRY = 5;

  typedef logic [NUM_BTNS-1:0] btn_vec_t;

  // $clog2(1) is 0, which would give a zero-width counter, so clamp to 1 bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/debouncer.sv
// ---------------------------------------------------------------------------
// debouncer
//
// Purpose:
//   Handles one raw button bit. The bit goes through a two-flop synchroniser.
//   It is accepted as a new level only after it has differed from the current
//   accepted level for DEBOUNCE_CYCLES consecutive clocks. Any single cycle
//   that agrees with the accepted level restarts the count.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing clocks needed to accept a change
//
// Ports:
//   clock     system clock, rising edge
//   reset     synchronous, active-high; clears synchroniser, counter, level
//   raw_i     asynchronous raw button level
//   stable_o  accepted (debounced) level
//   rise_o    high in the cycle whose clock edge flips stable_o from 0 to 1
// ---------------------------------------------------------------------------
module debouncer
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 650000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level. Reaching the last count while it still disagrees flips
  // the level. Both a flip and an agreeing cycle leave the counter at zero.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // The synchroniser pair, the counter and the accepted level all reset to
  // zero. A reset during debouncing therefore throws away the partial count,
  // and the input has to pass through the synchroniser again.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // rise_o is reported in the same cycle as the edge that updates stable_q.
  // A frame tick in that cycle can then fold the press straight into its
  // update.
  assign rise_o   = stable_d & ~stable_q;
  assign stable_o = stable_q;

endmodule

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//
// Purpose:
//   Input front end for the game logic. It debounces the six board buttons
//   and republishes them once per video frame, on the detected falling edge
//   of vsync. For each button it provides:
//     - a frame-stable debounced level
//     - a one-frame press flag
//   A press is flagged even when the whole tap happened between two ticks.
//
// Optional feature (macro INPUT_AUTO_REPEAT_EN):
//   When the macro is defined, holding a direction button (left/right/up/down)
//   produces repeated press flags:
//     - the first repeat comes REPEAT_DELAY frames after the press frame
//     - later repeats come every REPEAT_PERIOD frames
//   Chop and carry never repeat. Without the macro the repeat counters are not
//   built and the REPEAT_* parameters have no effect.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable clocks needed to accept a button change
//   REPEAT_DELAY     frames held before the first repeat (<= 255)
//   REPEAT_PERIOD    frames between later repeats (1 <= PERIOD <= DELAY)
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-high
//   vsync       raw vsync, asynchronous
//   btn_raw     raw buttons: 0 left, 1 right, 2 up, 3 down, 4 chop, 5 carry
//   frame_tick  one-clock pulse per detected vsync falling edge
//   btn_level   debounced levels, updated on frame_tick
//   btn_press   press/repeat flags, held for one frame
// ---------------------------------------------------------------------------
module input_conditioner
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_PERIOD   = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                vsync,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic                frame_tick,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press
);

  logic     vs1_q;
  logic     vs2_q;
  logic     vs3_q;
  logic     tick_s;

  btn_vec_t stable_s;
  btn_vec_t rise_s;
  btn_vec_t rep_fire_s;

  btn_vec_t pend_q;
  btn_vec_t pend_d;
  btn_vec_t level_q;
  btn_vec_t level_d;
  btn_vec_t press_q;
  btn_vec_t press_d;

  // vsync passes through two synchroniser flops. The third flop holds the
  // previous synchronised value for edge detection. All three reset low, so
  // the first rise of vsync after reset cannot look like a falling edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      vs1_q <= 1'b0;
      vs2_q <= 1'b0;
      vs3_q <= 1'b0;
    end else begin
      vs1_q <= vsync;
      vs2_q <= vs1_q;
      vs3_q <= vs2_q;
    end
  end

  // Falling edge: the previous value was high and the current value is low.
  assign tick_s     = vs3_q & ~vs2_q;
  assign frame_tick = tick_s;

  // One debouncer per button, each with its own synchroniser and counter.
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_deb
    debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clock   (clock),
      .reset   (reset),
      .raw_i   (btn_raw[i]),
      .stable_o(stable_s[i]),
      .rise_o  (rise_s[i])
    );
  end

`ifdef INPUT_AUTO_REPEAT_EN
  localparam logic [7:0] REP_DELAY  = 8'(REPEAT_DELAY);
  localparam logic [7:0] REP_RELOAD = 8'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [7:0] rep_cnt_q [NUM_REPEAT_BTNS];
  logic [7:0] rep_cnt_d [NUM_REPEAT_BTNS];

  // Repeat counters only move on a frame tick.
  //   - Level held across the tick: the counter counts up.
  //   - Counter reaches REPEAT_DELAY: a repeat fires, and the counter reloads
  //     so that the next repeat comes REPEAT_PERIOD frames later.
  //   - New level low: the counter clears.
  //   - Press frame (old level low, new level high): the counter holds at 0.
  //     The press itself is flagged through the pending/rise path instead.
  always_comb begin
    rep_fire_s = '0;
    for (int i = 0; i < NUM_REPEAT_BTNS; i++) begin
      rep_cnt_d[i] = rep_cnt_q[i];
      if (tick_s) begin
        if (!stable_s[i]) begin
          rep_cnt_d[i] = '0;
        end else if (level_q[i]) begin
          if (rep_cnt_q[i] + 8'd1 == REP_DELAY) begin
            rep_fire_s[i] = 1'b1;
            rep_cnt_d[i]  = REP_RELOAD;
          end else begin
            rep_cnt_d[i] = rep_cnt_q[i] + 8'd1;
          end
        end
      end
    end
  end

  // Repeat counter state for the direction buttons only.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REPEAT_BTNS; i++) begin
        rep_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REPEAT_BTNS; i++) begin
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
    end
  end
`else
  assign rep_fire_s = '0;
`endif

  // Between ticks, pend collects every accepted rising edge, so a tap that
  // is over before the next tick is still reported. On a tick:
  //   - the current stable levels are published
  //   - the press flags are built from pend, a rise landing in this very
  //     cycle, and any repeat firing
  //   - pend clears
  // Outside ticks the published outputs hold their values.
  always_comb begin
    pend_d  = pend_q | rise_s;
    level_d = level_q;
    press_d = press_q;
    if (tick_s) begin
      level_d = stable_s;
      press_d = pend_q | rise_s | rep_fire_s;
      pend_d  = '0;
    end
  end

  // Published frame state and pending presses.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q  <= '0;
      level_q <= '0;
      press_q <= '0;
    end else begin
      pend_q  <= pend_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign btn_level = level_q;
  assign btn_press = press_q;

endmodule

// File: tb/tb_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_input_conditioner
//
// Directed bench for input_conditioner. It uses a short debounce (8 clocks),
// REPEAT_DELAY 4 and REPEAT_PERIOD 2. Frames are generated by hand: vsync
// idles high and is dropped for a few clocks whenever a tick is wanted.
// Expectations for the auto-repeat scenario follow INPUT_AUTO_REPEAT_EN.
// ---------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int DEB    = 8;
  localparam int RDELAY = 4;
  localparam int RPER   = 2;

  logic       clock;
  logic       reset;
  logic       vsync;
  logic [5:0] btn_raw;
  logic       frame_tick;
  logic [5:0] btn_level;
  logic [5:0] btn_press;

  int tests_run;
  int tests_failed;

  input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDELAY),
    .REPEAT_PERIOD  (RPER)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .vsync     (vsync),
    .btn_raw   (btn_raw),
    .frame_tick(frame_tick),
    .btn_level (btn_level),
    .btn_press (btn_press)
  );

  // 10 ns system clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Wait a number of clocks; returns just after a falling edge, where the
  // inputs are driven.
  task automatic wait_clocks(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drop vsync and observe the outputs:
  //   - after the 2nd rising edge: the tick should be high and the outputs
  //     not yet updated
  //   - after the 3rd rising edge: the outputs are updated and the tick is low
  // vsync then returns high.
  task automatic do_tick(output logic [5:0] lvl_pre, output logic [5:0] prs_pre,
                         output logic tick_pre, output logic [5:0] lvl,
                         output logic [5:0] prs, output logic tick_post);
    @(negedge clock) vsync = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    tick_pre = frame_tick;
    lvl_pre  = btn_level;
    prs_pre  = btn_press;
    @(posedge clock); #1;
    tick_post = frame_tick;
    lvl       = btn_level;
    prs       = btn_press;
    repeat (2) @(posedge clock);
    @(negedge clock) vsync = 1'b1;
  endtask

  // Outputs must be 0 under reset and right after it, and an idle frame
  // must publish nothing.
  task automatic test_reset();
    logic [5:0] lp, pp, l, p;
    logic       tp, tq;
    repeat (3) @(posedge clock); #1;
    tests_run++;
    if (frame_tick !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_tick got %b want 0", frame_tick); end
    tests_run++;
    if (btn_level !== 6'b0) begin tests_failed++; $display("[TB] FAIL reset_level got %b want 000000", btn_level); end
    tests_run++;
    if (btn_press !== 6'b0) begin tests_failed++; $display("[TB] FAIL reset_press got %b want 000000", btn_press); end
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    tests_run++;
    if ({frame_tick, btn_level, btn_press} !== 13'b0) begin
      tests_failed++; $display("[TB] FAIL post_reset_outputs got %b want 0", {frame_tick, btn_level, btn_press});
    end
    wait_clocks(10);
    do_tick(lp, pp, tp, l, p, tq);
    tests_run++;
    if (tp !== 1'b1 || tq !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL idle_tick_pulse got %b%b want 10", tp, tq);
    end
    tests_run++;
    if ({l, p} !== 12'b0) begin tests_failed++; $display("[TB] FAIL idle_frame got %b want 0", {l, p}); end
  endtask

  // Chop toggles every 3 clocks for 40 clocks. The accepted level must never
  // move, and 3 frames must publish nothing.
  task automatic test_bounce();
    logic [5:0] lp, pp, l, p;
    logic       tp, tq;
    logic       moved;
    moved = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (k % 3 == 0) btn_raw[4] = ~btn_raw[4];
      if (dut.stable_s[4] !== 1'b0) moved = 1'b1;
    end
    btn_raw[4] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (dut.stable_s[4] !== 1'b0) moved = 1'b1;
    end
    tests_run++;
    if (moved !== 1'b0) begin tests_failed++; $display("[TB] FAIL bounce_stable got moved=%b want 0", moved); end
    for (int f = 0; f < 3; f++) begin
      do_tick(lp, pp, tp, l, p, tq);
      tests_run++;
      if ({l, p} !== 12'b0) begin
        tests_failed++; $display("[TB] FAIL bounce_frame%0d got level=%b press=%b want 0/0", f, l, p);
      end
      wait_clocks(10);
    end
  endtask

  // Up held for 3 frames: press on the first frame only, level held, and the
  // update lands exactly 3 clocks after vsync falls.
  task automatic test_clean_press();
    logic [5:0] lp, pp, l, p;
    logic       tp, tq;
    btn_raw[2] = 1'b1;
    wait_clocks(15);
    do_tick(lp, pp, tp, l, p, tq);
    tests_run++;
    if ({lp, pp} !== 12'b0) begin
      tests_failed++; $display("[TB] FAIL press_early_update got level=%b press=%b want 0/0", lp, pp);
    end
    tests_run++;
    if (l !== 6'b000100 || p !== 6'b000100) begin
      tests_failed++; $display("[TB] FAIL press_frame0 got level=%b press=%b want 000100/000100", l, p);
    end
    tests_run++;
    if (tp !== 1'b1 || tq !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL press_tick_pulse got %b%b want 10", tp, tq);
    end
    for (int f = 1; f < 3; f++) begin
      wait_clocks(15);
      do_tick(lp, pp, tp, l, p, tq);
      tests_run++;
      if (l !== 6'b000100 || p !== 6'b000000) begin
        tests_failed++; $display("[TB] FAIL press_frame%0d got level=%b press=%b want 000100/000000", f, l, p);
      end
    end
    btn_raw[2] = 1'b0;
    wait_clocks(15);
    do_tick(lp, pp, tp, l, p, tq);
    tests_run++;
    if ({l, p} !== 12'b0) begin
      tests_failed++; $display("[TB] FAIL press_release got level=%b press=%b want 0/0", l, p);
    end
  endtask

  // Right is accepted high for about 10 clocks and released between ticks.
  // The next tick shows a press with level 0; the tick after that shows none.
  task automatic test_short_tap();
    logic [5:0] lp, pp, l, p;
    logic       tp, tq;
    wait_clocks(5);
    btn_raw[1] = 1'b1;
    wait_clocks(20);
    btn_raw[1] = 1'b0;
    wait_clocks(15);
    do_tick(lp, pp, tp, l, p, tq);
    tests_run++;
    if (l !== 6'b000000 || p !== 6'b000010) begin
      tests_failed++; $display("[TB] FAIL tap_frame got level=%b press=%b want 000000/000010", l, p);
    end
    wait_clocks(15);
    do_tick(lp, pp, tp, l, p, tq);
    tests_run++;
    if ({l, p} !== 12'b0) begin
      tests_failed++; $display("[TB] FAIL tap_next got level=%b press=%b want 0/0", l, p);
    end
  endtask

  // Left and carry held for 12 frames. Left repeats on frames 4, 6, 8 and 10
  // only when the repeat feature is built; carry never repeats.
  task automatic test_auto_repeat();
    logic [5:0] lp, pp, l, p;
    logic       tp, tq;
    logic [5:0] exp_p;
    logic       rep_on;
`ifdef INPUT_AUTO_REPEAT_EN
    rep_on = 1'b1;
`else
    rep_on = 1'b0;
`endif
    btn_raw[0] = 1'b1;
    btn_raw[5] = 1'b1;
    wait_clocks(15);
    for (int f = 0; f < 12; f++) begin
      do_tick(lp, pp, tp, l, p, tq);
      exp_p    = 6'b0;
      exp_p[5] = (f == 0);
      exp_p[0] = (f == 0) || (rep_on && f >= 4 && (f % 2 == 0));
      tests_run++;
      if (p !== exp_p) begin
        tests_failed++; $display("[TB] FAIL repeat_press_f%0d got %b want %b", f, p, exp_p);
      end
      tests_run++;
      if (l !== 6'b100001) begin
        tests_failed++; $display("[TB] FAIL repeat_level_f%0d got %b want 100001", f, l);
      end
      wait_clocks(15);
    end
    btn_raw[0] = 1'b0;
    btn_raw[5] = 1'b0;
    wait_clocks(15);
    do_tick(lp, pp, tp, l, p, tq);
    tests_run++;
    if ({l, p} !== 12'b0) begin
      tests_failed++; $display("[TB] FAIL repeat_release got level=%b press=%b want 0/0", l, p);
    end
  endtask

  // Up is published first so that the outputs are nonzero. Then down is
  // pressed and reset is asserted once its count has reached 5. Outputs must
  // read 0 during and after reset. Down then needs the full 2 + 8 clocks
  // again before it is accepted.
  task automatic test_reset_mid_debounce();
    logic [5:0] lp, pp, l, p;
    logic       tp, tq;
    btn_raw[2] = 1'b1;
    wait_clocks(15);
    do_tick(lp, pp, tp, l, p, tq);
    tests_run++;
    if (l !== 6'b000100 || p !== 6'b000100) begin
      tests_failed++; $display("[TB] FAIL pre_reset_frame got level=%b press=%b want 000100/000100", l, p);
    end
    wait_clocks(5);
    btn_raw[3] = 1'b1;
    wait_clocks(7);
    reset = 1'b1;
    @(posedge clock); #1;
    tests_run++;
    if ({frame_tick, btn_level, btn_press} !== 13'b0) begin
      tests_failed++; $display("[TB] FAIL in_reset_outputs got %b want 0", {frame_tick, btn_level, btn_press});
    end
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    tests_run++;
    if ({frame_tick, btn_level, btn_press} !== 13'b0) begin
      tests_failed++; $display("[TB] FAIL after_reset_outputs got %b want 0", {frame_tick, btn_level, btn_press});
    end
    repeat (8) @(posedge clock); #1;
    tests_run++;
    if (dut.stable_s[3] !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL mid_reset_early got stable=%b want 0", dut.stable_s[3]);
    end
    @(posedge clock); #1;
    tests_run++;
    if (dut.stable_s[3] !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL mid_reset_accept got stable=%b want 1", dut.stable_s[3]);
    end
    wait_clocks(5);
    do_tick(lp, pp, tp, l, p, tq);
    tests_run++;
    if (l !== 6'b001100 || p !== 6'b001100) begin
      tests_failed++; $display("[TB] FAIL post_reset_frame got level=%b press=%b want 001100/001100", l, p);
    end
    btn_raw = 6'b0;
  endtask

  // Run the scenarios in order and print the summary.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    vsync        = 1'b1;
    btn_raw      = 6'b0;
    test_reset();
    test_bounce();
    test_clean_press();
    test_short_tap();
    test_auto_repeat();
    test_reset_mid_debounce();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage feeding the game state machine and player movement with button inputs. It takes six raw board buttons in the `clock` domain, synchronises and debounces each one, and republishes them once per video frame. Each button gets a frame-stable level and a one-frame press pulse, both aligned to the vsync falling edge where the game logic samples its inputs. Optional auto-repeat on the direction buttons lets menu letters scroll while a button is held.

## Interface
- `DEBOUNCE_CYCLES`, 650000: consecutive stable clocks required to accept a change (10 ms at 65 MHz).
- `REPEAT_DELAY`, 20: frames held before the first repeat press.
- `REPEAT_PERIOD`, 6: frames between subsequent repeats; must satisfy 1 ≤ PERIOD ≤ DELAY ≤ 255.
- `clock` in 1: system clock. All logic runs on the rising edge.
- `reset` in 1: synchronous, active-high.
- `vsync` in 1: raw vsync, asynchronous to this block's sampling.
- `btn_raw` in 6: raw buttons. Bit mapping is 0 left, 1 right, 2 up, 3 down, 4 chop, 5 carry.
- `frame_tick` out 1: one-clock pulse on each detected vsync falling edge.
- `btn_level` out 6: debounced level, latched at `frame_tick`.
- `btn_press` out 6: asserted for exactly one frame (tick to next tick) when a press or repeat occurred.

## Operation
- **Sync.** Each `btn_raw` bit passes through 2 flops, and `vsync` passes through 2 flops. A third `vsync` flop provides edge detection: `frame_tick = prev & ~cur`.
- **Debounce, per bit.**
  - `stable` is the accepted value.
  - While the synced input ≠ `stable`, a counter increments. Any cycle in which the input equals `stable` clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES−1 with the input still differing, `stable` flips and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES)`.
- **Pending press, per bit.** A 0→1 transition of `stable` sets `pend`.
- **Frame update on `frame_tick`.**
  - `btn_level <= stable`.
  - `btn_press[i] <= pend[i] | rise_now[i] | rep_fire[i]`.
  - `pend` clears. A rise in the tick cycle itself counts toward this tick.
  - A tap that both rises and falls between two ticks still yields `btn_press`=1 for one frame while `btn_level` stays 0.
- **Between ticks.** `btn_level` and `btn_press` hold their values.
- **Reset values.** Every output is 0. All `stable`, `pend`, counters and sync flops are 0, so no spurious tick or press occurs after reset. Reset mid-debounce discards the partial count.

## Timing
- `btn_level`/`btn_press` change 3 clocks after `vsync` falls (2 sync stages + edge register). They are stable for the rest of the frame, so a consumer clocked on negedge `vsync` samples the previous frame's values.
- Press-to-visible latency is 2 + DEBOUNCE_CYCLES clocks to `stable`, plus the wait to the next tick.
- `frame_tick` is high for exactly 1 clock per frame.

## Configuration
- Macro `INPUT_AUTO_REPEAT_EN`.
- **Defined:** bits 0–3 each have an 8-bit `rep_cnt`.
  - At each tick, if the new level = 1 and the old level = 1, `rep_cnt` increments.
  - When `rep_cnt` reaches REPEAT_DELAY, `rep_fire`=1 and `rep_cnt` reloads to REPEAT_DELAY−REPEAT_PERIOD.
  - A tick with new level 0 clears `rep_cnt`.
  - Bits 4–5 never repeat.
- **Undefined:** `rep_cnt` logic is absent, `rep_fire` ≡ 0, and REPEAT_* are ignored.

## Structure
- **Shared package `input_pkg`:**
  - Index constants `BTN_LEFT`=0, `BTN_RIGHT`=1, `BTN_UP`=2, `BTN_DOWN`=3, `BTN_CHOP`=4, `BTN_CARRY`=5.
  - `NUM_BTNS`=6.
  - Typedef `btn_vec_t` (logic [5:0]).
- **Sub-module `debouncer`:** one bit, containing the sync pair, counter and `stable`. It outputs `stable` and a `rise` pulse, and is instantiated 6 times via generate.

## Test plan
Use DEBOUNCE_CYCLES=8, REPEAT_DELAY=4 and REPEAT_PERIOD=2 for sim.
- **Bounce:** toggle `btn_raw[4]` every 3 clocks for 40 clocks, then hold 0 → `stable` never changes, and `btn_press`/`btn_level` stay 0 across 3 frames.
- **Clean press:** hold `btn_raw[2]`=1 for 3 frames → the first tick after `stable` rises gives `btn_level[2]`=1 and `btn_press[2]`=1. The next tick gives `btn_press[2]`=0 with level still 1. Outputs update exactly 3 clocks after `vsync` falls.
- **Short tap:** rise plus 10 clocks high, then release, all between two ticks → at that tick `btn_press`=1 and `btn_level`=0, for one frame only.
- **Auto-repeat (macro defined):** hold `btn_raw[0]` for 12 frames → `btn_press[0]`=1 on frames 0, 4, 6, 8, 10. Holding `btn_raw[5]` the same way gives a press on frame 0 only.
- **Auto-repeat (macro undefined):** same stimulus → `btn_press[0]` only on frame 0.
- **Reset mid-debounce:** assert `reset` after 5 stable clocks of a press, release reset with the button still high → 8 further clocks are needed before `stable`=1. All outputs read 0 during and immediately after reset.
